// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes,
// FSM state encodings and divider iteration count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes, one quotient bit per
// cycle; quotient/remainder are presented alongside done for same-edge capture.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic                 run;
  logic [DIV_CNT_W-1:0] cnt;
  logic [31:0]          rem, quo, dvs;
  logic [32:0]          rem_sh;
  logic                 fits;

  always_comb begin
    rem_sh    = {rem, quo[31]};
    fits      = rem_sh >= {1'b0, dvs};
    remainder = fits ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
    quotient  = {quo[30:0], fits};
  end

  assign done = run && (cnt == DIV_CNT_W'(DIV_ITERS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (run) begin
      rem <= remainder;
      quo <= quotient;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: FSM, HI/LO registers, multiplier pipeline
// and divide sign fixup. MULDIV_EARLY_OUT_EN enables 1-cycle DIV when |rt|>|rs|.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        cancel_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY_EN = 1'b1;
`else
  localparam logic EARLY_EN = 1'b0;
`endif

  localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES);

  md_state_e   state;
  md_op_e      op;
  logic [2:0]  mul_cnt;
  logic [63:0] mul_pipe [MUL_STAGES];
  logic [63:0] mul_a, mul_b, mul_prod;
  logic [31:0] rs_q, dvd_mag, dvs_mag, div_quo, div_rem;
  logic        quo_neg_q, rem_neg_q, dz_q, early_q;
  logic        accept, is_signed, is_mul, is_div, rs_neg, rt_neg;
  logic        early_c, div_start, div_done;

  assign op        = md_op_e'(req_op_i);
  assign ready_o   = (state == ST_IDLE) && !cancel_i;
  assign busy_o    = (state != ST_IDLE);
  assign accept    = req_valid_i && ready_o;
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign is_mul    = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign rs_neg    = is_signed && rs_i[31];
  assign rt_neg    = is_signed && rt_i[31];

  // Sign-extending to 64 bits lets one unsigned multiply serve both variants.
  assign mul_a    = {{32{rs_neg}}, rs_i};
  assign mul_b    = {{32{rt_neg}}, rt_i};
  assign mul_prod = mul_a * mul_b;

  assign dvd_mag   = magnitude(rs_i, rs_neg);
  assign dvs_mag   = magnitude(rt_i, rt_neg);
  assign early_c   = EARLY_EN && (dvs_mag != 32'd0) && (dvs_mag > dvd_mag);
  assign div_start = accept && is_div && !early_c;

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (cancel_i),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    rdata_o = '0;
    if (accept && op == MD_MFHI) rdata_o = hi_o;
    if (accept && op == MD_MFLO) rdata_o = lo_o;
  end

  always_ff @(posedge clk) begin
    if (accept && is_mul) mul_pipe[0] <= mul_prod;
    for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      mul_cnt   <= '0;
      hi_o      <= '0;
      lo_o      <= '0;
      rs_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                state   <= ST_MUL;
                mul_cnt <= 3'd1;
              end
              MD_DIV, MD_DIVU: begin
                state     <= ST_DIV;
                rs_q      <= rs_i;
                quo_neg_q <= rs_neg ^ rt_neg;
                rem_neg_q <= rs_neg;
                dz_q      <= (rt_i == 32'd0);
                early_q   <= early_c;
              end
              MD_MTHI: hi_o <= rs_i;
              MD_MTLO: lo_o <= rs_i;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cancel_i) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
          end else if (mul_cnt == MUL_LAST) begin
            {hi_o, lo_o} <= mul_pipe[MUL_STAGES-1];
            state        <= ST_IDLE;
            mul_cnt      <= '0;
          end else begin
            mul_cnt <= mul_cnt + 3'd1;
          end
        end
        ST_DIV: begin
          if (cancel_i) begin
            state <= ST_IDLE;
          end else if (div_done || early_q) begin
            state <= ST_IDLE;
            if (dz_q) begin
              lo_o <= 32'hFFFF_FFFF;
              hi_o <= rs_q;
            end else if (early_q) begin
              lo_o <= '0;
              hi_o <= rs_q;
            end else begin
              lo_o <= quo_neg_q ? -div_quo : div_quo;
              hi_o <= rem_neg_q ? -div_rem : div_rem;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_STAGES=2); expected
// DIVU 3/10 latency follows MULDIV_EARLY_OUT_EN.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn, req_valid, cancel;
  logic [2:0]  req_op;
  logic [31:0] rs, rt;
  logic        ready, busy;
  logic [31:0] rdata, hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  int cycles;
  int stalls;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 32;
`endif

  muldiv_ctrl #(.MUL_STAGES(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .rs_i        (rs),
    .rt_i        (rt),
    .cancel_i    (cancel),
    .ready_o     (ready),
    .busy_o      (busy),
    .rdata_o     (rdata),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then count busy cycles until busy drops (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    req_valid = 1'b1;
    req_op    = op;
    rs        = a;
    rt        = b;
    tick();
    req_valid = 1'b0;
    rs        = 32'hDEAD_BEEF;
    rt        = 32'h0BAD_F00D;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; cancel = 1'b0;
    req_op = 3'd0; rs = '0; rt = '0;
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_ready", 64'(ready), 64'h1);
    check("reset_rdata", 64'(rdata), 64'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles);
    check("multu_lat", 64'(cycles), 64'd2);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    check("multu_ready", 64'(ready), 64'h1);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, cycles);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF1);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cycles);
    check("div_lat", 64'(cycles), 64'd32);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(3'd3, 32'd100, 32'd7, cycles);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
    check("ovf_lo", 64'(lo), 64'h8000_0000);
    check("ovf_hi", 64'(hi), 64'h0);

    run_op(3'd3, 32'd5, 32'd0, cycles);
    check("dz_lat", 64'(cycles), 64'd32);
    check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("dz_hi", 64'(hi), 64'd5);

    // DIV 100 / -7 with an MFLO held behind it.
    req_valid = 1'b1; req_op = 3'd2; rs = 32'd100; rt = 32'hFFFF_FFF9;
    tick();
    req_op = 3'd5;
    cycles = 0; stalls = 0;
    while (busy && cycles < 200) begin
      if (!ready) stalls++;
      cycles++;
      tick();
    end
    check("stall_busy", 64'(cycles), 64'd32);
    check("stall_ready_low", 64'(stalls), 64'd32);
    check("mflo_ready", 64'(ready), 64'h1);
    check("mflo_rdata", 64'(rdata), 64'hFFFF_FFF2);
    tick();
    req_op = 3'd4;
    #1;
    check("mfhi_rdata", 64'(rdata), 64'd2);
    tick();
    req_valid = 1'b0;
    #1;
    check("rdata_idle", 64'(rdata), 64'h0);

    run_op(3'd6, 32'h0000_1234, 32'd0, cycles);
    check("mthi", 64'(hi), 64'h1234);
    run_op(3'd7, 32'h0000_5678, 32'd0, cycles);
    check("mtlo", 64'(lo), 64'h5678);

    // Cancel in busy cycle 10.
    req_valid = 1'b1; req_op = 3'd3; rs = 32'd100; rt = 32'd7;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    check("c10_busy", 64'(busy), 64'h1);
    cancel = 1'b1;
    #1;
    check("c10_ready_low", 64'(ready), 64'h0);
    tick();
    cancel = 1'b0;
    #1;
    check("c10_idle", 64'(busy), 64'h0);
    check("c10_ready", 64'(ready), 64'h1);
    check("c10_hi", 64'(hi), 64'h1234);
    check("c10_lo", 64'(lo), 64'h5678);

    // Cancel coincident with the completion edge.
    req_valid = 1'b1; req_op = 3'd3; rs = 32'd100; rt = 32'd7;
    tick();
    req_valid = 1'b0;
    repeat (31) tick();
    check("c32_busy", 64'(busy), 64'h1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    #1;
    check("c32_idle", 64'(busy), 64'h0);
    check("c32_hi", 64'(hi), 64'h1234);
    check("c32_lo", 64'(lo), 64'h5678);

    // Cancel in IDLE blocks a request.
    req_valid = 1'b1; req_op = 3'd6; rs = 32'h0000_DEAD; cancel = 1'b1;
    #1;
    check("cidle_ready", 64'(ready), 64'h0);
    tick();
    req_valid = 1'b0; cancel = 1'b0;
    #1;
    check("cidle_hi", 64'(hi), 64'h1234);

    run_op(3'd3, 32'd3, 32'd10, cycles);
    check("early_lat", 64'(cycles), 64'(EARLY_LAT));
    check("early_lo", 64'(lo), 64'h0);
    check("early_hi", 64'(hi), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
